// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between four result
// sources, with a pending-write scoreboard that flags RAW/WAW hazards to decode.
module wb_port_arbiter #(
  parameter int XLEN = 32,
  parameter int NSRC = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NSRC-1:0]      i_src_valid,
  input  logic [NSRC*5-1:0]    i_src_waddr,
  input  logic [NSRC*XLEN-1:0] i_src_wdata,
  output logic [NSRC-1:0]      o_src_ready,
  input  logic                 i_issue_valid,
  input  logic                 i_issue_wen,
  input  logic [4:0]           i_issue_rd,
  input  logic [4:0]           i_issue_rs1,
  input  logic [4:0]           i_issue_rs2,
  output logic                 o_issue_hazard,
  output logic                 o_rd_wvalid,
  output logic [4:0]           o_rd_waddr,
  output logic [XLEN-1:0]      o_rd_wdata,
  output logic                 o_idle
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   cand;
  logic            found;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     pend;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  // Scan sources starting at the pointer; the first valid one wins.
  always_comb begin
    o_src_ready = '0;
    gidx        = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = PW'((int'(ptr) + k) % NSRC);
      if (!found && i_src_valid[cand]) begin
        found             = 1'b1;
        gidx              = cand;
        o_src_ready[cand] = 1'b1;
      end
    end
  end

  assign sel_addr = i_src_waddr[gidx*5 +: 5];
  assign sel_data = i_src_wdata[gidx*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(NSRC - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Writes to x0 are consumed but dropped, so address/data keep the last real write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd_wvalid <= 1'b0;
      o_rd_waddr  <= '0;
      o_rd_wdata  <= '0;
    end else if (found && (sel_addr != 5'd0)) begin
      o_rd_wvalid <= 1'b1;
      o_rd_waddr  <= sel_addr;
      o_rd_wdata  <= sel_data;
    end else begin
      o_rd_wvalid <= 1'b0;
    end
  end

  assign o_issue_hazard = i_issue_valid &
                          (pend[i_issue_rs1] | pend[i_issue_rs2] | (i_issue_wen & pend[i_issue_rd]));

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (o_rd_wvalid) begin
      clr_mask[o_rd_waddr] = 1'b1;
    end
    if (i_issue_valid && i_issue_wen && !o_issue_hazard && (i_issue_rd != 5'd0)) begin
      set_mask[i_issue_rd] = 1'b1;
    end
  end

  // Set is applied after clear so a newly issued writer keeps its bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
    end else begin
      pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign o_idle = (pend == 32'd0) & ~o_rd_wvalid & ~(|i_src_valid);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of arbitration, output stage and scoreboard.
module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int NSRC = 4;

  logic                 clk;
  logic                 rstn;
  logic [NSRC-1:0]      i_src_valid;
  logic [NSRC*5-1:0]    i_src_waddr;
  logic [NSRC*XLEN-1:0] i_src_wdata;
  logic [NSRC-1:0]      o_src_ready;
  logic                 i_issue_valid;
  logic                 i_issue_wen;
  logic [4:0]           i_issue_rd;
  logic [4:0]           i_issue_rs1;
  logic [4:0]           i_issue_rs2;
  logic                 o_issue_hazard;
  logic                 o_rd_wvalid;
  logic [4:0]           o_rd_waddr;
  logic [XLEN-1:0]      o_rd_wdata;
  logic                 o_idle;

  wb_port_arbiter #(.XLEN(XLEN), .NSRC(NSRC)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_src_valid   (i_src_valid),
    .i_src_waddr   (i_src_waddr),
    .i_src_wdata   (i_src_wdata),
    .o_src_ready   (o_src_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_wen   (i_issue_wen),
    .i_issue_rd    (i_issue_rd),
    .i_issue_rs1   (i_issue_rs1),
    .i_issue_rs2   (i_issue_rs2),
    .o_issue_hazard(o_issue_hazard),
    .o_rd_wvalid   (o_rd_wvalid),
    .o_rd_waddr    (o_rd_waddr),
    .o_rd_wdata    (o_rd_wdata),
    .o_idle        (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        src_v[NSRC];
  logic [4:0]  src_a[NSRC];
  logic [31:0] src_d[NSRC];

  // Model state: pointer, registered write port, pending set of registers.
  int          p_m;
  logic        wv_m;
  logic [4:0]  wa_m;
  logic [31:0] wd_m;
  bit          pend_m[32];
  int          last_g;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    p_m    = 0;
    wv_m   = 1'b0;
    wa_m   = '0;
    wd_m   = '0;
    last_g = -1;
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
  endtask

  task automatic packInputs();
    for (int s = 0; s < NSRC; s++) begin
      i_src_valid[s]         = src_v[s];
      i_src_waddr[5*s +: 5]  = src_a[s];
      i_src_wdata[32*s +: 32] = src_d[s];
    end
  endtask

  task automatic clearInputs();
    for (int s = 0; s < NSRC; s++) begin
      src_v[s] = 1'b0;
      src_a[s] = '0;
      src_d[s] = '0;
    end
    i_issue_valid = 1'b0;
    i_issue_wen   = 1'b0;
    i_issue_rd    = '0;
    i_issue_rs1   = '0;
    i_issue_rs2   = '0;
    packInputs();
  endtask

  // Drives one cycle of inputs, checks every output against the model, then steps both.
  task automatic applyStimulus();
    int         g;
    int         idx;
    logic [3:0] exp_ready;
    logic       exp_haz;
    logic       any_pend;
    packInputs();
    #3;
    g = -1;
    for (int k = 0; k < NSRC; k++) begin
      idx = (p_m + k) % NSRC;
      if (g < 0 && src_v[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_haz = i_issue_valid && (pend_m[i_issue_rs1] || pend_m[i_issue_rs2] ||
                                (i_issue_wen && pend_m[i_issue_rd]));
    any_pend = 1'b0;
    for (int i = 0; i < 32; i++) if (pend_m[i]) any_pend = 1'b1;
    checkOutput("ready", 32'(o_src_ready), 32'(exp_ready));
    checkOutput("hazard", 32'(o_issue_hazard), 32'(exp_haz));
    checkOutput("idle", 32'(o_idle), 32'(!any_pend && !wv_m && (g < 0)));
    checkOutput("wvalid", 32'(o_rd_wvalid), 32'(wv_m));
    checkOutput("waddr", 32'(o_rd_waddr), 32'(wa_m));
    checkOutput("wdata", o_rd_wdata, wd_m);
    if (wv_m) pend_m[wa_m] = 1'b0;
    if (i_issue_valid && i_issue_wen && !exp_haz && i_issue_rd != 0) pend_m[i_issue_rd] = 1'b1;
    if (g >= 0 && src_a[g] != 0) begin
      wv_m = 1'b1;
      wa_m = src_a[g];
      wd_m = src_d[g];
    end else begin
      wv_m = 1'b0;
    end
    if (g >= 0) p_m = (g + 1) % NSRC;
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    clearInputs();
    resetModel();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic setIssue(input logic v, input logic wen, input int rd, input int rs1, input int rs2);
    i_issue_valid = v;
    i_issue_wen   = wen;
    i_issue_rd    = 5'(rd);
    i_issue_rs1   = 5'(rs1);
    i_issue_rs2   = 5'(rs2);
  endtask

  initial begin
    rstn = 1'b0;
    clearInputs();
    resetModel();
    #12;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then a single int request
    applyStimulus();
    src_v[1] = 1'b1; src_a[1] = 5'd5; src_d[1] = 32'hDEADBEEF;
    applyStimulus();
    src_v[1] = 1'b0;
    applyStimulus();
    applyStimulus();

    // All sources held valid for eight cycles
    doReset();
    for (int s = 0; s < NSRC; s++) begin
      src_v[s] = 1'b1; src_a[s] = 5'(s + 1); src_d[s] = 32'h1000 + 32'(s);
    end
    for (int c = 0; c < 8; c++) applyStimulus();
    clearInputs();
    applyStimulus();

    // RAW hazard on rd=7 released by an int write-back
    doReset();
    setIssue(1, 1, 7, 0, 0);
    applyStimulus();
    setIssue(1, 0, 0, 7, 0);
    applyStimulus();
    src_v[1] = 1'b1; src_a[1] = 5'd7; src_d[1] = 32'h77;
    applyStimulus();
    src_v[1] = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    // WAW stall on rd=3 and writes to x0
    setIssue(1, 1, 3, 0, 0);
    applyStimulus();
    applyStimulus();
    setIssue(1, 1, 0, 0, 0);
    applyStimulus();
    setIssue(0, 0, 0, 0, 0);
    src_v[2] = 1'b1; src_a[2] = 5'd0; src_d[2] = 32'h1234;
    applyStimulus();
    src_v[2] = 1'b0;
    src_v[3] = 1'b1; src_v[0] = 1'b1; src_a[3] = 5'd3; src_d[3] = 32'h33;
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();

    // Asynchronous reset while a write is in flight and pend[9] is set
    doReset();
    setIssue(1, 1, 9, 0, 0);
    src_v[1] = 1'b1; src_a[1] = 5'd4; src_d[1] = 32'hCAFE;
    applyStimulus();
    clearInputs();
    setIssue(1, 0, 0, 9, 0);
    #1;
    checkOutput("pre_rst_wvalid", 32'(o_rd_wvalid), 32'd1);
    checkOutput("pre_rst_hazard", 32'(o_issue_hazard), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_wvalid", 32'(o_rd_wvalid), 32'd0);
    checkOutput("rst_hazard", 32'(o_issue_hazard), 32'd0);
    checkOutput("rst_idle", 32'(o_idle), 32'd1);
    setIssue(0, 0, 0, 0, 0);
    resetModel();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus();
    applyStimulus();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        if ((src_v[s] && last_g == s) || !src_v[s]) begin
          src_v[s] = ($urandom_range(0, 9) < 4);
          src_a[s] = 5'($urandom_range(0, 7));
          src_d[s] = $urandom;
        end
      end
      setIssue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7));
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
